// File: rtl/vga_pkg.sv
// Shared VGA timing types and constants for the controller and receive sides.
// Combinational helpers only, so this file adds no latency.
// Not applicable: this file carries no data path and no flow control.
package vga_pkg;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2
    } rx_state_t;

    localparam int VGA_H_TOTAL  = 800;
    localparam int VGA_V_TOTAL  = 525;
    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_COORD_W  = 10;
    localparam int VGA_MEAS_W   = 11;

    // Increment that sticks at all-ones; used for the measurement counters.
    function automatic logic [VGA_MEAS_W-1:0] sat_inc_meas(input logic [VGA_MEAS_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Increment that sticks at all-ones; used for the pixel coordinates.
    function automatic logic [VGA_COORD_W-1:0] sat_inc_coord(input logic [VGA_COORD_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/vga_sync_edge.sv
// Falling-edge detector for an active-low sync line, qualified by the pixel strobe.
// fall is combinational on the strobed sample; history register updates only on pix_en.
// No backpressure: samples are taken whenever pix_en is high and ignored otherwise.
module vga_sync_edge (
    input  logic clk_in,
    input  logic rst,
    input  logic pix_en,
    input  logic level,
    output logic fall
);

    logic prev;

    // Remember the last strobed level; idles high so a line held low at reset is not an edge.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            prev <= 1'b1;
        end else if (pix_en) begin
            prev <= level;
        end
    end

    assign fall = pix_en & prev & ~level;

endmodule

// File: rtl/vga_sync_receiver.sv
// VGA timing receiver: recovers active-pixel coordinates, measures line/frame length, declares lock.
// Latency 1 clk_in from a pix_en tick to every output; pulses last exactly one clk_in.
// No backpressure: pix_en gates all progress. Optional VGA_RX_CHECKSUM_EN adds frame_sum.
module vga_sync_receiver
    import vga_pkg::*;
#(
    parameter int H_TOTAL     = VGA_H_TOTAL,
    parameter int V_TOTAL     = VGA_V_TOTAL,
    parameter int LOCK_FRAMES = 2
) (
    input  logic                   clk_in,
    input  logic                   rst,
    input  logic                   pix_en,
    input  logic                   h_sync,
    input  logic                   v_sync,
    input  logic                   n_blank,
    input  logic [7:0]             R,
    input  logic [7:0]             G,
    input  logic [7:0]             B,
    output logic                   pix_valid,
    output logic [VGA_COORD_W-1:0] pix_x,
    output logic [VGA_COORD_W-1:0] pix_y,
    output logic [23:0]            pix_rgb,
    output logic                   frame_start,
    output logic [VGA_MEAS_W-1:0]  h_meas,
    output logic [VGA_MEAS_W-1:0]  v_meas,
    output logic                   h_err,
    output logic                   v_err,
`ifdef VGA_RX_CHECKSUM_EN
    output logic [23:0]            frame_sum,
`endif
    output logic                   locked
);

    localparam logic [VGA_MEAS_W-1:0] H_TOT  = VGA_MEAS_W'(H_TOTAL);
    localparam logic [VGA_MEAS_W-1:0] V_TOT  = VGA_MEAS_W'(V_TOTAL);
    localparam logic [3:0]            LOCK_N = 4'(LOCK_FRAMES);

    logic                   h_fall, v_fall;
    logic [VGA_MEAS_W-1:0]  h_cnt, line_cnt, line_len, lines_closed;
    logic [VGA_COORD_W-1:0] x_cnt, y_cnt, x_cur, y_cur;
    logic                   line_has_pix, line_bad, frame_bad, pix_take;
    rx_state_t              state, state_nxt;
    logic [3:0]             good_cnt, good_cnt_nxt;
    logic                   v_err_nxt;

    vga_sync_edge u_h_edge (.clk_in(clk_in), .rst(rst), .pix_en(pix_en), .level(h_sync), .fall(h_fall));
    vga_sync_edge u_v_edge (.clk_in(clk_in), .rst(rst), .pix_en(pix_en), .level(v_sync), .fall(v_fall));

    // A line that closes on the same tick as v fall still belongs to the ending frame.
    assign line_len     = sat_inc_meas(h_cnt);
    assign line_bad     = (line_len != H_TOT);
    assign lines_closed = h_fall ? sat_inc_meas(line_cnt) : line_cnt;
    assign frame_bad    = (lines_closed != V_TOT) | h_err | (h_fall & line_bad);
    assign pix_take     = pix_en & n_blank & (state != SEARCH);
    assign x_cur        = h_fall ? '0 : x_cnt;
    assign y_cur        = v_fall ? '0 :
                          (h_fall & line_has_pix) ? sat_inc_coord(y_cnt) : y_cnt;

    // Acquisition FSM: only v fall ticks move it, and each one grades the frame just ended.
    always_comb begin
        state_nxt    = state;
        good_cnt_nxt = good_cnt;
        v_err_nxt    = 1'b0;
        if (v_fall) begin
            case (state)
                SEARCH: begin
                    state_nxt    = SYNC;
                    good_cnt_nxt = '0;
                end
                SYNC: begin
                    if (frame_bad) begin
                        good_cnt_nxt = '0;
                        v_err_nxt    = 1'b1;
                    end else begin
                        good_cnt_nxt = good_cnt + 4'd1;
                        if (good_cnt_nxt == LOCK_N) state_nxt = LOCKED;
                    end
                end
                LOCKED: begin
                    if (frame_bad) begin
                        state_nxt    = SYNC;
                        good_cnt_nxt = '0;
                        v_err_nxt    = 1'b1;
                    end
                end
                default: begin
                    state_nxt    = SEARCH;
                    good_cnt_nxt = '0;
                end
            endcase
        end
    end

    // FSM state plus its registered status outputs.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            state       <= SEARCH;
            good_cnt    <= '0;
            locked      <= 1'b0;
            v_err       <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            state       <= state_nxt;
            good_cnt    <= good_cnt_nxt;
            locked      <= (state_nxt == LOCKED);
            v_err       <= v_err_nxt;
            frame_start <= v_fall;
        end
    end

    // Line and frame length measurement; v_meas is only meaningful once acquisition has begun.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            h_cnt    <= '0;
            line_cnt <= '0;
            h_meas   <= '0;
            v_meas   <= '0;
            h_err    <= 1'b0;
        end else if (pix_en) begin
            h_cnt <= h_fall ? '0 : sat_inc_meas(h_cnt);
            if (h_fall) h_meas <= line_len;
            if (v_fall) begin
                line_cnt <= '0;
                if (state != SEARCH) v_meas <= lines_closed;
            end else if (h_fall) begin
                line_cnt <= sat_inc_meas(line_cnt);
            end
            if (v_fall)                h_err <= 1'b0;
            else if (h_fall & line_bad) h_err <= 1'b1;
        end
    end

    // Pixel path: coordinates of the current tick are published one cycle later.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            pix_valid    <= 1'b0;
            pix_x        <= '0;
            pix_y        <= '0;
            pix_rgb      <= '0;
            x_cnt        <= '0;
            y_cnt        <= '0;
            line_has_pix <= 1'b0;
        end else begin
            pix_valid <= pix_take;
            if (pix_en) begin
                if (pix_take) begin
                    pix_x   <= x_cur;
                    pix_y   <= y_cur;
                    pix_rgb <= {R, G, B};
                    x_cnt   <= sat_inc_coord(x_cur);
                end else begin
                    x_cnt   <= x_cur;
                end
                y_cnt        <= y_cur;
                line_has_pix <= ((h_fall | v_fall) ? 1'b0 : line_has_pix) | pix_take;
            end
        end
    end

`ifdef VGA_RX_CHECKSUM_EN
    logic [23:0] sum_acc;

    // Per-frame colour checksum, published at each v fall once acquisition has begun.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            sum_acc   <= '0;
            frame_sum <= '0;
        end else if (pix_en) begin
            if (v_fall) begin
                if (state != SEARCH) frame_sum <= sum_acc;
                sum_acc <= pix_take ? {R, G, B} : 24'd0;
            end else if (pix_take) begin
                sum_acc <= sum_acc + {R, G, B};
            end
        end
    end
`endif

endmodule

// File: tb/tb_vga_sync_receiver.sv
// Randomised frame generator with a line/frame level reference model for vga_sync_receiver.
// Checks every output one cycle after each pix_en tick or idle cycle.
// Idle cycles (pix_en low) carry random garbage on all inputs.
module tb_vga_sync_receiver;

    localparam int HT  = 24;   // line length in ticks
    localparam int VT  = 10;   // lines per frame
    localparam int LK  = 2;
    localparam int HS  = 3;    // h sync width
    localparam int HBP = 2;    // h back porch
    localparam int HA  = 16;   // active pixels per line
    localparam int VB  = 3;    // first active line
    localparam int VA  = 6;    // active lines

    logic        clk_in = 1'b0;
    logic        rst, pix_en, h_sync, v_sync, n_blank;
    logic [7:0]  R, G, B;
    logic        pix_valid, frame_start, h_err, v_err, locked;
    logic [9:0]  pix_x, pix_y;
    logic [23:0] pix_rgb;
    logic [10:0] h_meas, v_meas;
`ifdef VGA_RX_CHECKSUM_EN
    logic [23:0] frame_sum;
`endif

    always #5 clk_in = ~clk_in;

    vga_sync_receiver #(.H_TOTAL(HT), .V_TOTAL(VT), .LOCK_FRAMES(LK)) dut (
        .clk_in(clk_in), .rst(rst), .pix_en(pix_en), .h_sync(h_sync), .v_sync(v_sync),
        .n_blank(n_blank), .R(R), .G(G), .B(B),
        .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_rgb(pix_rgb),
        .frame_start(frame_start), .h_meas(h_meas), .v_meas(v_meas),
        .h_err(h_err), .v_err(v_err),
`ifdef VGA_RX_CHECKSUM_EN
        .frame_sum(frame_sum),
`endif
        .locked(locked)
    );

    int n_chk = 0;
    int n_fail = 0;

    // Reference model state, expressed in lines and frames.
    int acq, good_run, lines_in_frame, frame_bad, last_len;
    int model_pix, dut_pix, sum_model;
    int e_pv, e_x, e_y, e_rgb, e_fs, e_hm, e_vm, e_he, e_ve, e_lk, e_fsum;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        check_eq("pix_valid",   32'(pix_valid),   e_pv);
        check_eq("pix_x",       32'(pix_x),       e_x);
        check_eq("pix_y",       32'(pix_y),       e_y);
        check_eq("pix_rgb",     32'(pix_rgb),     e_rgb);
        check_eq("frame_start", 32'(frame_start), e_fs);
        check_eq("h_meas",      32'(h_meas),      e_hm);
        check_eq("v_meas",      32'(v_meas),      e_vm);
        check_eq("h_err",       32'(h_err),       e_he);
        check_eq("v_err",       32'(v_err),       e_ve);
        check_eq("locked",      32'(locked),      e_lk);
`ifdef VGA_RX_CHECKSUM_EN
        check_eq("frame_sum",   32'(frame_sum),   e_fsum);
`endif
        if (pix_valid) dut_pix++;
    endtask

    task automatic model_clear();
        acq = 0; good_run = 0; lines_in_frame = 0; frame_bad = 0; last_len = 1;
        model_pix = 0; dut_pix = 0; sum_model = 0;
        e_pv = 0; e_x = 0; e_y = 0; e_rgb = 0; e_fs = 0; e_hm = 0; e_vm = 0;
        e_he = 0; e_ve = 0; e_lk = 0; e_fsum = 0;
    endtask

    task automatic idle();
        pix_en  = 1'b0;
        h_sync  = 1'($urandom());
        v_sync  = 1'($urandom());
        n_blank = 1'($urandom());
        {R, G, B} = 24'($urandom());
        e_pv = 0; e_fs = 0; e_ve = 0;
        @(negedge clk_in);
        check_outputs();
    endtask

    task automatic do_reset();
        pix_en = 1'b0;
        rst    = 1'b1;
        @(negedge clk_in);
        rst = 1'b0;
        model_clear();
        check_outputs();
    endtask

    // One pix_en tick; hf/vf mark where the generator put the sync falling edges.
    task automatic do_tick(input bit hs, input bit vs, input bit nb, input bit hf, input bit vf,
                           input int col, input int row, input int closed_len);
        logic [23:0] rgb;
        int meas;
        while ($urandom_range(0, 3) == 0) idle();
        rgb  = 24'($urandom());
        e_pv = 0; e_fs = vf ? 1 : 0; e_ve = 0;
        if (hf) begin
            meas = (closed_len > 2047) ? 2047 : closed_len;
            e_hm = meas;
            lines_in_frame++;
            if (meas != HT) begin
                e_he = 1;
                frame_bad = 1;
            end
        end
        if (nb && acq != 0) begin
            e_pv  = 1;
            e_x   = (col > 1023) ? 1023 : col;
            e_y   = (row > 1023) ? 1023 : row;
            e_rgb = int'(rgb);
            model_pix++;
            sum_model = (sum_model + int'(rgb)) & 32'hFFFFFF;
        end
        if (vf) begin
            if (acq != 0) begin
                check_eq("frame_pix_count", dut_pix, model_pix);
                e_vm   = lines_in_frame;
                e_fsum = sum_model;
                if (frame_bad != 0 || lines_in_frame != VT) begin
                    good_run = 0;
                    e_ve = 1;
                    e_lk = 0;
                end else begin
                    good_run++;
                    if (good_run >= LK) e_lk = 1;
                end
            end else begin
                acq = 1;
            end
            lines_in_frame = 0; frame_bad = 0; e_he = 0;
            model_pix = 0; dut_pix = 0; sum_model = 0;
        end
        pix_en = 1'b1; h_sync = hs; v_sync = vs; n_blank = nb; {R, G, B} = rgb;
        @(negedge clk_in);
        check_outputs();
    endtask

    // Generate one frame; bad_idx line gets bad_len ticks (and bad_act pixels if >0).
    task automatic run_frame(input int nlines, input int bad_idx, input int bad_len,
                             input int bad_act, input int stall_line, input int rst_line);
        int voff, len, act;
        bit hs, vs, nb;
        voff = $urandom_range(0, 2);
        for (int ln = 0; ln < nlines; ln++) begin
            len = (ln == bad_idx) ? bad_len : HT;
            act = (ln >= VB && ln < VB + VA) ? ((ln == bad_idx && bad_act > 0) ? bad_act : HA) : 0;
            for (int t = 0; t < len; t++) begin
                if (ln == rst_line && t == 10) begin
                    do_reset();
                    return;
                end
                if (ln == stall_line && t == HS + HBP + 5) repeat (100) idle();
                hs = (t >= HS);
                vs = !((ln == 0 && t >= voff) || ln == 1);
                nb = (act > 0) && (t >= HS + HBP) && (t < HS + HBP + act);
                do_tick(hs, vs, nb, t == 0, ln == 0 && t == voff, t - HS - HBP, ln - VB, last_len);
            end
            last_len = len;
        end
    endtask

    initial begin
        rst = 1'b1; pix_en = 1'b0; h_sync = 1'b1; v_sync = 1'b1; n_blank = 1'b0;
        R = 8'd0; G = 8'd0; B = 8'd0;
        model_clear();
        repeat (3) @(negedge clk_in);
        do_reset();

        run_frame(VT, -1, 0, 0, 4, -1);             // acquire, with a 100-cycle stall mid-line
        repeat (2) run_frame(VT, -1, 0, 0, -1, -1); // lock after two good frames
        run_frame(VT, 5, HT + 1, 0, -1, -1);        // one stretched line
        repeat (2) run_frame(VT, -1, 0, 0, -1, -1); // relock
        run_frame(VT + 1, -1, 0, 0, -1, -1);        // frame one line too long
        run_frame(VT, 4, 2100, 1030, -1, -1);       // saturating line length and x
        repeat (2) run_frame(VT, -1, 0, 0, -1, -1);
        run_frame(VT, -1, 0, 0, -1, 4);             // reset mid-line while locked
        repeat (4) run_frame(VT, -1, 0, 0, -1, -1); // reacquire after reset
        run_frame(3, -1, 0, 0, -1, -1);             // close the last full frame
        repeat (3) idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
